// File: rtl/ascon_pack.sv
// Shared Ascon definitions: the 320-bit state type, round constants, sbox and
// linear-layer rotate amounts.
package ascon_pack;

  // x0 occupies the most significant 64 bits of the packed 320-bit state.
  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } type_state;

  typedef enum logic {StIdle, StRun} fsm_e;

  localparam logic [3:0] LAST_ROUND = 4'd11;

  localparam int unsigned ROT_X0_A = 19;
  localparam int unsigned ROT_X0_B = 28;
  localparam int unsigned ROT_X1_A = 61;
  localparam int unsigned ROT_X1_B = 39;
  localparam int unsigned ROT_X2_A = 1;
  localparam int unsigned ROT_X2_B = 6;
  localparam int unsigned ROT_X3_A = 10;
  localparam int unsigned ROT_X3_B = 17;
  localparam int unsigned ROT_X4_A = 7;
  localparam int unsigned ROT_X4_B = 41;

  function automatic logic [7:0] round_const(input logic [3:0] r);
    return {4'd15 - r, r};
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [4:0] sbox(input logic [4:0] x);
    logic [4:0] y;
    unique case (x)
      5'd0:  y = 5'h04;  5'd1:  y = 5'h0b;  5'd2:  y = 5'h1f;  5'd3:  y = 5'h14;
      5'd4:  y = 5'h1a;  5'd5:  y = 5'h15;  5'd6:  y = 5'h09;  5'd7:  y = 5'h02;
      5'd8:  y = 5'h1b;  5'd9:  y = 5'h05;  5'd10: y = 5'h08;  5'd11: y = 5'h12;
      5'd12: y = 5'h1d;  5'd13: y = 5'h03;  5'd14: y = 5'h06;  5'd15: y = 5'h1c;
      5'd16: y = 5'h1e;  5'd17: y = 5'h13;  5'd18: y = 5'h07;  5'd19: y = 5'h0e;
      5'd20: y = 5'h00;  5'd21: y = 5'h0d;  5'd22: y = 5'h11;  5'd23: y = 5'h18;
      5'd24: y = 5'h10;  5'd25: y = 5'h0c;  5'd26: y = 5'h01;  5'd27: y = 5'h19;
      5'd28: y = 5'h16;  5'd29: y = 5'h0a;  5'd30: y = 5'h0f;  default: y = 5'h17;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/round_ascon.sv
// One combinational Ascon round: constant addition, bit-sliced sbox, linear layer.
module round_ascon
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);

  type_state  s_c;
  type_state  s_s;
  logic [4:0] col;

  always_comb begin
    s_c = state_i;
    s_c.x2[7:0] = s_c.x2[7:0] ^ round_const(round_i);

    s_s = '0;
    col = '0;
    // Each of the 64 columns is one 5-bit sbox input, x0 as the MSB.
    for (int i = 0; i < 64; i++) begin
      col = sbox({s_c.x0[i], s_c.x1[i], s_c.x2[i], s_c.x3[i], s_c.x4[i]});
      s_s.x0[i] = col[4];
      s_s.x1[i] = col[3];
      s_s.x2[i] = col[2];
      s_s.x3[i] = col[1];
      s_s.x4[i] = col[0];
    end

    state_o.x0 = s_s.x0 ^ ror64(s_s.x0, ROT_X0_A) ^ ror64(s_s.x0, ROT_X0_B);
    state_o.x1 = s_s.x1 ^ ror64(s_s.x1, ROT_X1_A) ^ ror64(s_s.x1, ROT_X1_B);
    state_o.x2 = s_s.x2 ^ ror64(s_s.x2, ROT_X2_A) ^ ror64(s_s.x2, ROT_X2_B);
    state_o.x3 = s_s.x3 ^ ror64(s_s.x3, ROT_X3_A) ^ ror64(s_s.x3, ROT_X3_B);
    state_o.x4 = s_s.x4 ^ ror64(s_s.x4, ROT_X4_A) ^ ror64(s_s.x4, ROT_X4_B);
  end

endmodule

// File: rtl/permutation_iter.sv
// Iterative Ascon permutation p^a / p^b: one round per clock, the first round
// applied on the start edge itself, finishing on round index 11.
module permutation_iter
  import ascon_pack::*;
#(
  parameter int unsigned PA_ROUNDS = 12,
  parameter int unsigned PB_ROUNDS = 6
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_pb_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [3:0] R0_PA = 4'(12 - PA_ROUNDS);
  localparam logic [3:0] R0_PB = 4'(12 - PB_ROUNDS);

  fsm_e       fsm_q;
  type_state  state_q;
  logic [3:0] round_q;
  logic       busy_q;
  logic       done_q;

  type_state  rnd_in;
  type_state  rnd_out;
  logic [3:0] rnd_idx;

  // In IDLE the round datapath works directly on the incoming state so the
  // start edge already applies the first round.
  always_comb begin
    if (fsm_q == StIdle) begin
      rnd_in  = state_i;
      rnd_idx = mode_pb_i ? R0_PB : R0_PA;
    end else begin
      rnd_in  = state_q;
      rnd_idx = round_q + 4'd1;
    end
  end

  round_ascon u_round (
    .state_i (rnd_in),
    .round_i (rnd_idx),
    .state_o (rnd_out)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (fsm_q)
        StIdle: begin
          if (start_i) begin
            state_q <= rnd_out;
            round_q <= rnd_idx;
            if (rnd_idx == LAST_ROUND) begin
              done_q <= 1'b1;
            end else begin
              busy_q <= 1'b1;
              fsm_q  <= StRun;
            end
          end
        end
        StRun: begin
          state_q <= rnd_out;
          round_q <= rnd_idx;
          if (rnd_idx == LAST_ROUND) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            fsm_q  <= StIdle;
          end
        end
        default: fsm_q <= StIdle;
      endcase
    end
  end

  assign state_o = state_q;
  assign round_o = round_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule
